// File: rtl/gpu_pkg.sv
// Shared GPU definitions: fragment-writer FSM encoding and default widths.
package gpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } fw_state_e;

  localparam int unsigned FW_FIFO_DEPTH = 4;
  localparam int unsigned FW_COORD_W    = 4;
  localparam int unsigned FW_COLOR_W    = 8;

endpackage

// File: rtl/frag_fifo.sv
// Power-of-two circular FIFO; exposes the head and the entry behind it so the
// writer can reload its output register in the same cycle it pops.
module frag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic             multi,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign rd_nxt = rd_ptr_q + AW'(1);
  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign multi  = (cnt_q > (AW+1)'(1));
  assign head   = mem_q[rd_ptr_q];
  assign next   = mem_q[rd_nxt];

endmodule

// File: rtl/frag_writer.sv
// Buffers rasterized fragments and writes them to the framebuffer, or fills the
// whole framebuffer on a clear request. FRAG_WRITER_COUNT_EN adds frag_count.
module frag_writer
  import gpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FW_FIFO_DEPTH,
  parameter int unsigned COORD_W    = FW_COORD_W,
  parameter int unsigned COLOR_W    = FW_COLOR_W
) (
  input  logic                 c,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COORD_W-1:0]   in_x,
  input  logic [COORD_W-1:0]   in_y,
  input  logic [COLOR_W-1:0]   in_color,
  input  logic                 in_last,
  input  logic                 clr_req,
  input  logic [COLOR_W-1:0]   clr_color,
  output logic                 fb_we,
  output logic [2*COORD_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_wdata,
  input  logic                 fb_ready,
  output logic                 busy,
  output logic                 line_done
`ifdef FRAG_WRITER_COUNT_EN
  ,
  output logic [15:0]          frag_count
`endif
);

  localparam int unsigned AW_FB = 2*COORD_W;
  localparam int unsigned EW    = 2*COORD_W + COLOR_W + 1;

  fw_state_e          state_q, state_d;
  logic               fb_we_q, fb_we_d;
  logic [AW_FB-1:0]   fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0] fb_wdata_q, fb_wdata_d;
  logic               fb_last_q, fb_last_d;
  logic               clr_pend_q, clr_pend_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic               line_done_q, line_done_d;
  logic               rdy_en_q;

  logic               push, pop, full, empty, multi, wr_done, load;
  logic [EW-1:0]      din, head, next, src;

  assign din      = {in_x, in_y, in_color, in_last};
  assign in_ready = rdy_en_q && !full && (state_q != ST_CLEAR) && !clr_pend_q;
  assign push     = in_valid && in_ready;
  assign wr_done  = fb_we_q && fb_ready;
  assign pop      = wr_done && (state_q == ST_DRAIN);

  frag_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (c),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .multi (multi),
    .head  (head),
    .next  (next)
  );

  always_comb begin
    state_d     = state_q;
    fb_we_d     = fb_we_q;
    fb_addr_d   = fb_addr_q;
    fb_wdata_d  = fb_wdata_q;
    fb_last_d   = fb_last_q;
    clr_pend_d  = clr_pend_q;
    clr_color_d = clr_color_q;
    line_done_d = pop && fb_last_q;
    load        = 1'b0;
    src         = head;

    if (clr_req && !clr_pend_q && (state_q != ST_CLEAR)) begin
      clr_pend_d  = 1'b1;
      clr_color_d = clr_color;
    end

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_DRAIN;
        end else if (clr_pend_q) begin
          state_d    = ST_CLEAR;
          clr_pend_d = 1'b0;
          fb_we_d    = 1'b1;
          fb_addr_d  = '0;
          fb_wdata_d = clr_color_q;
          fb_last_d  = 1'b0;
        end
      end
      ST_DRAIN: begin
        // The output register holds the head; on completion reload from the
        // entry behind it so back-to-back writes need no bubble.
        if (wr_done) begin
          if (multi) begin
            load = 1'b1;
            src  = next;
          end else begin
            fb_we_d = 1'b0;
            if (!push) state_d = ST_IDLE;
          end
        end else if (!fb_we_q) begin
          if (!empty) load = 1'b1;
          else        state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (wr_done) begin
          if (fb_addr_q == '1) begin
            fb_we_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            fb_addr_d = fb_addr_q + AW_FB'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      fb_we_d    = 1'b1;
      fb_addr_d  = {src[EW-1-COORD_W -: COORD_W], src[EW-1 -: COORD_W]};
      fb_wdata_d = src[COLOR_W:1];
      fb_last_d  = src[0];
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      fb_last_q   <= 1'b0;
      clr_pend_q  <= 1'b0;
      clr_color_q <= '0;
      line_done_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
      fb_last_q   <= fb_last_d;
      clr_pend_q  <= clr_pend_d;
      clr_color_q <= clr_color_d;
      line_done_q <= line_done_d;
      rdy_en_q    <= 1'b1;
    end
  end

  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign line_done = line_done_q;
  assign busy      = (state_q == ST_CLEAR) || !empty;

`ifdef FRAG_WRITER_COUNT_EN
  logic [15:0] frag_count_q;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n)   frag_count_q <= '0;
    else if (pop) frag_count_q <= frag_count_q + 16'd1;
  end

  assign frag_count = frag_count_q;
`endif

endmodule

// File: tb/tb_frag_writer.sv
// Directed bench for frag_writer: table of single fragments, streaming,
// back-pressure, clear ordering and reset abort.
module tb_frag_writer;

  logic       c = 1'b0;
  logic       rst_n, in_valid, in_ready, in_last, clr_req;
  logic [3:0] in_x, in_y;
  logic [7:0] in_color, clr_color, fb_addr, fb_wdata;
  logic       fb_we, fb_ready, busy, line_done;
`ifdef FRAG_WRITER_COUNT_EN
  logic [15:0] frag_count;
`endif

  frag_writer #(
    .FIFO_DEPTH (4),
    .COORD_W    (4),
    .COLOR_W    (8)
  ) dut (
    .c         (c),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_color  (in_color),
    .in_last   (in_last),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .fb_ready  (fb_ready),
    .busy      (busy),
    .line_done (line_done)
`ifdef FRAG_WRITER_COUNT_EN
    ,
    .frag_count(frag_count)
`endif
  );

  always #5 c = ~c;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    int unsigned cyc;
  } wr_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] col;
    logic       last;
    logic [7:0] ea;
    logic [7:0] ed;
    logic       eld;
  } vec_t;

  wr_t         wq[$];
  int unsigned cyc = 0;
  int unsigned ld_cnt = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always @(posedge c) cyc <= cyc + 1;

  always @(negedge c) begin
    if (fb_we && fb_ready) wq.push_back('{fb_addr, fb_wdata, cyc});
    if (line_done) ld_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [7:0] col,
                      input logic last, output int unsigned acc);
    int unsigned n = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_color = col; in_last = last;
    @(negedge c);
    while (!in_ready && n < 50) begin
      @(negedge c);
      n++;
    end
    acc = cyc;
    if (!in_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge c);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_wq(input int unsigned n, input int unsigned budget, input string nm);
    int unsigned k = 0;
    while (wq.size() < n && k < budget) begin
      @(negedge c);
      #1;
      k++;
    end
    if (wq.size() < n) chk(nm, wq.size(), n);
  endtask

  task automatic pulse_clear(input logic [7:0] col);
    @(posedge c);
    #1 clr_req = 1'b1; clr_color = col;
    @(posedge c);
    #1 clr_req = 1'b0; clr_color = 8'hEE;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  vec_t        tv[6];
  vec_t        s2[22];
  int unsigned acc, ld0, bad;
  logic [7:0]  a0;
  logic        stable;

  initial begin
    tv[0] = '{4'h3, 4'h2, 8'h5A, 1'b1, 8'h23, 8'h5A, 1'b1};
    tv[1] = '{4'h0, 4'h0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    tv[2] = '{4'hF, 4'hF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1};
    tv[3] = '{4'hF, 4'h0, 8'h81, 1'b0, 8'h0F, 8'h81, 1'b0};
    tv[4] = '{4'h0, 4'hF, 8'h3C, 1'b1, 8'hF0, 8'h3C, 1'b1};
    tv[5] = '{4'hA, 4'h5, 8'hC3, 1'b0, 8'h5A, 8'hC3, 1'b0};
    for (int i = 0; i < 22; i++) begin
      s2[i].x    = 4'(i % 16);
      s2[i].y    = (i < 16) ? 4'd1 : 4'd2;
      s2[i].col  = 8'(16 + i);
      s2[i].last = (i == 21);
      s2[i].ea   = 8'(((i < 16) ? 16 : 32) + (i % 16));
      s2[i].ed   = 8'(16 + i);
      s2[i].eld  = (i == 21);
    end

    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_color = '0; in_last = 1'b0;
    clr_req = 1'b0; clr_color = '0; fb_ready = 1'b1;
    repeat (3) @(negedge c);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_wdata", fb_wdata, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge c);
    #1 rst_n = 1'b1;
    @(posedge c);
    @(negedge c);
    chk("ready_after_rst", in_ready, 1);

    // Single fragments from the table, each drained before the next.
    for (int i = 0; i < 6; i++) begin
      wq.delete();
      ld0 = ld_cnt;
      @(posedge c);
      #1;
      send(tv[i].x, tv[i].y, tv[i].col, tv[i].last, acc);
      wait_wq(1, 20, "vec_write_timeout");
      repeat (3) @(negedge c);
      #1;
      if (wq.size() > 0) begin
        chk("vec_addr", wq[0].addr, tv[i].ea);
        chk("vec_data", wq[0].data, tv[i].ed);
        if (i == 0) chk("vec_latency", wq[0].cyc - acc - 1, 2);
      end
      chk("vec_nwrites", wq.size(), 1);
      chk("vec_line_done", ld_cnt - ld0, 32'(tv[i].eld));
      chk("vec_busy_idle", busy, 0);
    end

    // Back-to-back stream of 22 fragments.
    wq.delete();
    ld0 = ld_cnt;
    @(posedge c);
    #1;
    for (int i = 0; i < 22; i++) send(s2[i].x, s2[i].y, s2[i].col, s2[i].last, acc);
    wait_wq(22, 60, "stream_timeout");
    repeat (3) @(negedge c);
    #1;
    if (wq.size() == 22) begin
      for (int i = 0; i < 22; i++) begin
        chk("stream_addr", wq[i].addr, s2[i].ea);
        chk("stream_data", wq[i].data, s2[i].ed);
      end
      chk("stream_throughput", wq[21].cyc - wq[0].cyc, 21);
    end
    chk("stream_nwrites", wq.size(), 22);
    chk("stream_line_done", ld_cnt - ld0, 1);

    // Back-pressure: fifth fragment waits until the framebuffer accepts.
    wq.delete();
    @(posedge c);
    #1 fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i + 1), 4'h7, 8'(8'hA0 + i), 1'b0, acc);
    in_valid = 1'b1; in_x = 4'h5; in_y = 4'h7; in_color = 8'hA4; in_last = 1'b1;
    @(negedge c);
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_fb_we", fb_we, 1);
    a0 = fb_addr;
    stable = 1'b1;
    repeat (3) begin
      @(negedge c);
      if (fb_addr !== a0 || fb_we !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp_addr_hold", a0, 8'h71);
    chk("bp_stable", stable, 1);
    @(posedge c);
    #1 fb_ready = 1'b1;
    begin
      int unsigned n = 0;
      @(negedge c);
      while (!in_ready && n < 20) begin
        @(negedge c);
        n++;
      end
      chk("bp_fifth_accepted", in_ready, 1);
      @(posedge c);
      #1 in_valid = 1'b0;
    end
    wait_wq(5, 30, "bp_timeout");
    repeat (2) @(negedge c);
    #1;
    chk("bp_nwrites", wq.size(), 5);
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      chk("bp_addr", wq[i].addr, 32'(8'h71 + i));
      chk("bp_data", wq[i].data, 32'(8'hA0 + i));
    end

    // Clear while three fragments are buffered.
    wq.delete();
    @(posedge c);
    #1 fb_ready = 1'b0;
    send(4'h1, 4'h3, 8'h11, 1'b0, acc);
    send(4'h2, 4'h3, 8'h22, 1'b0, acc);
    send(4'h3, 4'h3, 8'h33, 1'b1, acc);
    pulse_clear(8'h00);
    @(negedge c);
    chk("clr_pend_in_ready", in_ready, 0);
    chk("clr_pend_busy", busy, 1);
    @(posedge c);
    #1 fb_ready = 1'b1;
    wait_wq(50, 100, "clr_progress_timeout");
    chk("clr_busy_mid", busy, 1);
    wait_wq(100, 100, "clr_progress_timeout");
    pulse_clear(8'hFF);
    wait_wq(259, 400, "clr_timeout");
    repeat (5) @(negedge c);
    #1;
    chk("clr_nwrites", wq.size(), 259);
    chk("clr_busy_end", busy, 0);
    if (wq.size() >= 3) begin
      chk("clr_frag0", wq[0].addr, 8'h31);
      chk("clr_frag1", wq[1].addr, 8'h32);
      chk("clr_frag2", wq[2].addr, 8'h33);
    end
    bad = 0;
    for (int i = 0; i < 256 && i + 3 < wq.size(); i++)
      if (wq[i+3].addr !== 8'(i) || wq[i+3].data !== 8'h00) bad++;
    chk("clr_sequence_bad", bad, 0);

    // Reset in the middle of a clear.
    wq.delete();
    pulse_clear(8'h77);
    begin
      int unsigned n = 0;
      @(negedge c);
      while (!(fb_we && fb_addr == 8'h40) && n < 300) begin
        @(negedge c);
        n++;
      end
      chk("abort_reached_40", fb_addr, 8'h40);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_fb_we", fb_we, 0);
    chk("abort_fb_addr", fb_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    @(posedge c);
    @(posedge c);
    wq.delete();
    #1 rst_n = 1'b1;
    repeat (20) @(negedge c);
    #1;
    chk("abort_no_writes", wq.size(), 0);
    chk("abort_busy_after", busy, 0);
    chk("abort_ready_after", in_ready, 1);

`ifdef FRAG_WRITER_COUNT_EN
    chk("count_reset", frag_count, 0);
    wq.delete();
    @(posedge c);
    #1;
    send(4'h1, 4'h9, 8'h01, 1'b0, acc);
    send(4'h2, 4'h9, 8'h02, 1'b0, acc);
    send(4'h3, 4'h9, 8'h03, 1'b1, acc);
    pulse_clear(8'h42);
    wait_wq(259, 400, "count_clr_timeout");
    repeat (3) @(negedge c);
    chk("count_value", frag_count, 3);
`endif

    wq.delete();
    @(posedge c);
    #1;
    send(4'h1, 4'h1, 8'h99, 1'b1, acc);
    wait_wq(1, 20, "post_rst_timeout");
    if (wq.size() > 0) begin
      chk("post_rst_addr", wq[0].addr, 8'h11);
      chk("post_rst_data", wq[0].data, 8'h99);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frag_writer.md
FRAG_WRITER -- requirements
Module: frag_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4; number of buffered fragments, power of two, 2 to 16.
REQ-002 Parameter COORD_W, default 4; width of the x and y pixel coordinates.
REQ-003 Parameter COLOR_W, default 8; width of the pixel colour.
REQ-004 c  input  1  clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
REQ-006 in_valid  input  1  fragment offered by the upstream line-rasterizer stage.
REQ-007 in_ready  output  1  fragment accepted when in_valid and in_ready are both high on a rising edge.
REQ-008 in_x, in_y  input  COORD_W each  pixel coordinates.
REQ-009 in_color  input  COLOR_W  pixel colour.
REQ-010 in_last  input  1  marks the final fragment of a line.
REQ-011 clr_req  input  1  single-cycle pulse requesting a full framebuffer clear.
REQ-012 clr_color  input  COLOR_W  fill value, sampled in the cycle clr_req is high.
REQ-013 fb_we  output  1  framebuffer write strobe.
REQ-014 fb_addr  output  2*COORD_W  framebuffer address.
REQ-015 fb_wdata  output  COLOR_W  framebuffer write data.
REQ-016 fb_ready  input  1  framebuffer accepts the write when fb_we and fb_ready are both high.
REQ-017 busy  output  1  high in CLEAR, or whenever the FIFO is non-empty.
REQ-018 line_done  output  1  one-cycle pulse in the cycle after the write of an in_last fragment completes.

Function
REQ-019 fb_addr for a fragment SHALL equal {y, x}, i.e. y*2^COORD_W + x, with no overflow possible.
REQ-020 Accepted fragments SHALL enter a FIFO_DEPTH-entry FIFO holding {x, y, color, last}.
REQ-021 in_ready SHALL be high iff the FIFO is not full, the state is not CLEAR, and no clear is pending.
REQ-022 FSM states: IDLE, DRAIN, CLEAR.
REQ-023 IDLE -> DRAIN when the FIFO is non-empty; IDLE -> CLEAR when a clear is pending and the FIFO is empty.
REQ-024 DRAIN -> IDLE when the last entry's write completes and no new entry arrives in that cycle; otherwise remain in DRAIN.
REQ-025 CLEAR -> IDLE on the completed write to the final address, 2^(2*COORD_W)-1.
REQ-026 In DRAIN, fb_we SHALL present the FIFO head; the FIFO pops only on fb_we and fb_ready.
REQ-027 Writes SHALL be registered outputs: minimum latency from acceptance to fb_we is 2 cycles, and throughput is one write per cycle while fb_ready is high.
REQ-028 fb_addr and fb_wdata SHALL hold stable while fb_we is high and fb_ready is low.
REQ-029 A push and a pop in the same cycle with the FIFO full SHALL NOT be allowed, since in_ready is low when full; on a non-full FIFO they SHALL be allowed, leaving the count unchanged.
REQ-030 A clr_req seen in any state SHALL set a pending flag and latch clr_color; a second clr_req while pending or in CLEAR SHALL be ignored.
REQ-031 CLEAR SHALL write clr_color to addresses 0 up to 2^(2*COORD_W)-1 in ascending order, one per accepted write.
REQ-032 Fragments already buffered before a clear SHALL be written before the clear starts.

Reset
REQ-033 While rst_n is low, the block SHALL hold: state IDLE, FIFO empty, pending clear cleared, fb_we=0, fb_addr=0, fb_wdata=0, line_done=0, busy=0.
REQ-034 While rst_n is low, in_ready SHALL be 0; in_ready SHALL rise in the first cycle after reset release.
REQ-035 Reset asserted in mid-DRAIN or mid-CLEAR SHALL abandon the operation, with no further writes.

Configuration
REQ-036 With FRAG_WRITER_COUNT_EN defined, the block SHALL add a 16-bit output frag_count, reset to 0, that increments on every completed DRAIN write, wraps at 65535 to 0, and is not affected by CLEAR writes.
REQ-037 Without FRAG_WRITER_COUNT_EN, the port and the counter SHALL be absent.

Structure
REQ-038 A shared package gpu_pkg SHALL hold the FSM state encoding and the default width constants.
REQ-039 The FIFO SHALL be a sub-module frag_fifo, parameterised by depth and width, exposing push, pop, full, empty and head.

Verification
REQ-040 Scenario 1: reset release, then fragment (x=3, y=2, color=0x5A, last=1) with fb_ready=1 -> a single write to addr 0x23 with data 0x5A, followed by a line_done pulse.
REQ-041 Scenario 2: 22 back-to-back fragments x=0..21 (wrapping at 16), fb_ready=1 -> 22 writes in order, at one per cycle after the initial latency.
REQ-042 Scenario 3: fb_ready held low while 5 fragments are offered -> in_ready drops after 4 are accepted; fb_addr stays stable; all 5 fragments are written in order once fb_ready rises.
REQ-043 Scenario 4: clr_req with clr_color=0x00 while 3 fragments are buffered -> the 3 fragment writes come first, then 256 writes to addresses 0x00..0xFF, then busy falls.
REQ-044 Scenario 5: rst_n pulled low at CLEAR address 0x40 -> fb_we falls immediately, and no writes occur after release until new input arrives.
REQ-045 Scenario 6 (FRAG_WRITER_COUNT_EN): 3 fragments, then a clear -> frag_count reads 3.
